// File: rtl/ascii_frame_checker.sv
// ASCII frame recogniser for the UART receive path: START, digits, one math separator,
// capital letters, STOP; reports code/field lengths over valid/ready and counts frames.
module ascii_frame_checker #(
    parameter logic [7:0] START_CH    = 8'h23,
    parameter logic [7:0] STOP_CH     = 8'h23,
    parameter int         DMIN        = 2,
    parameter int         DMAX        = 4,
    parameter int         LMIN        = 1,
    parameter int         LMAX        = 3,
    parameter int         TIMEOUT_CYC = 0,
    parameter int         CNT_W       = 16,
    localparam int        DW          = $clog2(DMAX + 1),
    localparam int        LW          = $clog2(LMAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic [2:0]       res_code,
    output logic [DW-1:0]    res_digits,
    output logic [LW-1:0]    res_letters,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] bad_count
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYC > 0);

    localparam logic [DW-1:0] DMIN_V  = DW'(DMIN);
    localparam logic [DW-1:0] DMAX_V  = DW'(DMAX);
    localparam logic [LW-1:0] LMIN_V  = LW'(LMIN);
    localparam logic [LW-1:0] LMAX_V  = LW'(LMAX);
    localparam logic [TW-1:0] TLAST_V = TO_EN ? TW'(TIMEOUT_CYC - 1) : '0;

    localparam logic [2:0] CODE_OK      = 3'd0;
    localparam logic [2:0] CODE_BAD_CH  = 3'd1;
    localparam logic [2:0] CODE_DIGIT   = 3'd2;
    localparam logic [2:0] CODE_LETTER  = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_LETTERS = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_capital(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    function automatic logic is_separator(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F) || (c == 8'h3D);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [DW-1:0]   dcnt_r, dcnt_nxt_s;
    logic [LW-1:0]   lcnt_r, lcnt_nxt_s;
    logic [TW-1:0]   timer_r, timer_nxt_s;
    logic            done_s;
    logic [2:0]      code_s;
    logic            timeout_hit_s;
    logic            busy_r;
    logic            res_valid_r, res_ok_r;
    logic [2:0]      res_code_r;
    logic [DW-1:0]   res_digits_r;
    logic [LW-1:0]   res_letters_r;
    logic [CNT_W-1:0] ok_count_r, bad_count_r;

    assign timeout_hit_s = TO_EN && (timer_r == TLAST_V);

    // Next-state and frame evaluation on each received byte or timer tick.
    always_comb begin
        state_nxt_s = state_r;
        dcnt_nxt_s  = dcnt_r;
        lcnt_nxt_s  = lcnt_r;
        timer_nxt_s = timer_r;
        done_s      = 1'b0;
        code_s      = CODE_OK;
        case (state_r)
            ST_IDLE: begin
                if (char_valid && (char_in == START_CH)) begin
                    state_nxt_s = ST_DIGITS;
                    dcnt_nxt_s  = '0;
                    lcnt_nxt_s  = '0;
                    timer_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIGITS: begin
                if (char_valid) begin
                    timer_nxt_s = '0;
                    if (is_digit(char_in)) begin
                        if (dcnt_r < DMAX_V) begin
                            dcnt_nxt_s = dcnt_r + DW'(1'b1);
                        end else begin
                            done_s = 1'b1;
                            code_s = CODE_DIGIT;
                        end
                    end else if (is_separator(char_in)) begin
                        if (dcnt_r >= DMIN_V) begin
                            state_nxt_s = ST_LETTERS;
                        end else begin
                            done_s = 1'b1;
                            code_s = CODE_DIGIT;
                        end
                    end else begin
                        done_s = 1'b1;
                        code_s = CODE_BAD_CH;
                    end
                end else if (timeout_hit_s) begin
                    done_s = 1'b1;
                    code_s = CODE_TIMEOUT;
                end else begin
                    timer_nxt_s = timer_r + TW'(1'b1);
                end
            end
            ST_LETTERS: begin
                if (char_valid) begin
                    timer_nxt_s = '0;
                    // STOP is tested before the letter class so STOP may be any byte.
                    if (char_in == STOP_CH) begin
                        done_s = 1'b1;
                        code_s = (lcnt_r >= LMIN_V) ? CODE_OK : CODE_LETTER;
                    end else if (is_capital(char_in)) begin
                        if (lcnt_r < LMAX_V) begin
                            lcnt_nxt_s = lcnt_r + LW'(1'b1);
                        end else begin
                            done_s = 1'b1;
                            code_s = CODE_LETTER;
                        end
                    end else begin
                        done_s = 1'b1;
                        code_s = CODE_BAD_CH;
                    end
                end else if (timeout_hit_s) begin
                    done_s = 1'b1;
                    code_s = CODE_TIMEOUT;
                end else begin
                    timer_nxt_s = timer_r + TW'(1'b1);
                end
            end
            ST_REPORT: begin
                if (res_valid_r && res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (done_s) begin
            state_nxt_s = ST_REPORT;
        end else begin
            code_s = CODE_OK;
        end
    end

    // State, field counters, inter-character timer and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            dcnt_r  <= '0;
            lcnt_r  <= '0;
            timer_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
            timer_r <= timer_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Result register: loaded on completion, valid dropped on handshake, data retained.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r   <= 1'b0;
            res_ok_r      <= 1'b0;
            res_code_r    <= 3'd0;
            res_digits_r  <= '0;
            res_letters_r <= '0;
        end else if (done_s) begin
            res_valid_r   <= 1'b1;
            res_ok_r      <= (code_s == CODE_OK);
            res_code_r    <= code_s;
            res_digits_r  <= dcnt_nxt_s;
            res_letters_r <= lcnt_nxt_s;
        end else if (res_valid_r && res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    // Saturating accepted/rejected frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_count_r  <= '0;
            bad_count_r <= '0;
        end else if (done_s && (code_s == CODE_OK)) begin
            if (ok_count_r != {CNT_W{1'b1}}) begin
                ok_count_r <= ok_count_r + CNT_W'(1'b1);
            end
        end else if (done_s) begin
            if (bad_count_r != {CNT_W{1'b1}}) begin
                bad_count_r <= bad_count_r + CNT_W'(1'b1);
            end
        end
    end

    assign busy        = busy_r;
    assign res_valid   = res_valid_r;
    assign res_ok      = res_ok_r;
    assign res_code    = res_code_r;
    assign res_digits  = res_digits_r;
    assign res_letters = res_letters_r;
    assign ok_count    = ok_count_r;
    assign bad_count   = bad_count_r;

endmodule

// File: tb/tb_ascii_frame_checker.sv
// Randomised scoreboard bench for ascii_frame_checker: a string-level reference model
// predicts each result, a monitor compares the DUT's outputs every cycle.
module tb_ascii_frame_checker;

    localparam logic [7:0] START_CH = 8'h23;
    localparam logic [7:0] STOP_CH  = 8'h23;
    localparam int DMIN = 2, DMAX = 4, LMIN = 1, LMAX = 3;
    localparam int TO   = 20;
    localparam int CW   = 4;
    localparam int DW   = 3;
    localparam int LW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          ok;
        logic [2:0]    code;
        logic [DW-1:0] d;
        logic [LW-1:0] l;
    } res_t;

    typedef struct {
        bit         done;
        logic [2:0] code;
        int         d;
        int         l;
    } verdict_t;

    typedef logic [7:0] bq_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          busy, res_valid, res_ok;
    logic [2:0]    res_code;
    logic [DW-1:0] res_digits;
    logic [LW-1:0] res_letters;
    logic [CW-1:0] ok_count, bad_count;

    ascii_frame_checker #(
        .START_CH(START_CH), .STOP_CH(STOP_CH), .DMIN(DMIN), .DMAX(DMAX),
        .LMIN(LMIN), .LMAX(LMAX), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
        .res_code(res_code), .res_digits(res_digits), .res_letters(res_letters),
        .ok_count(ok_count), .bad_count(bad_count)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    res_t exp_q[$];
    bq_t  fbuf;
    bit   in_frame = 0, reporting = 0;
    int   gap = 0, exp_ok = 0, exp_bad = 0;
    bit   exp_busy = 0, exp_valid = 0;
    int   rdy_pct = 100;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, expv, $time);
        else n_pass++;
    endtask

    function automatic bit is_dig(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction
    function automatic bit is_cap(input logic [7:0] c);
        return c >= 8'h41 && c <= 8'h5A;
    endfunction
    function automatic bit is_sep(input logic [7:0] c);
        return c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F || c == 8'h3D;
    endfunction

    // Judge the bytes received after START as a whole string.
    function automatic verdict_t judge(input bq_t q);
        verdict_t v;
        int i;
        v.done = 0; v.code = 3'd0; v.d = 0; v.l = 0;
        i = 0;
        while (i < q.size() && is_dig(q[i])) i++;
        v.d = i;
        if (v.d > DMAX) begin v.done = 1; v.code = 3'd2; v.d = DMAX; return v; end
        if (i == q.size()) return v;
        if (!is_sep(q[i])) begin v.done = 1; v.code = 3'd1; return v; end
        if (v.d < DMIN) begin v.done = 1; v.code = 3'd2; return v; end
        for (int j = i + 1; j < q.size(); j++) begin
            if (q[j] == STOP_CH) begin
                v.done = 1; v.code = (v.l >= LMIN) ? 3'd0 : 3'd3; return v;
            end else if (is_cap(q[j])) begin
                v.l++;
                if (v.l > LMAX) begin v.l = LMAX; v.done = 1; v.code = 3'd3; return v; end
            end else begin
                v.done = 1; v.code = 3'd1; return v;
            end
        end
        return v;
    endfunction

    task automatic complete(input logic [2:0] code, input int d, input int l);
        res_t r;
        r.ok = (code == 3'd0); r.code = code; r.d = DW'(d); r.l = LW'(l);
        exp_q.push_back(r);
        in_frame = 0; reporting = 1;
        if (code == 3'd0) begin if (exp_ok < CMAX) exp_ok++; end
        else begin if (exp_bad < CMAX) exp_bad++; end
    endtask

    // Predict the effect of the upcoming clock edge given the inputs just driven.
    task automatic model_step(input logic cv, input logic [7:0] c, input logic rdy, input logic r);
        verdict_t v;
        if (r) begin
            in_frame = 0; reporting = 0; gap = 0; exp_ok = 0; exp_bad = 0;
        end else if (reporting) begin
            if (rdy) reporting = 0;
        end else if (in_frame) begin
            if (cv) begin
                fbuf.push_back(c); gap = 0;
                v = judge(fbuf);
                if (v.done) complete(v.code, v.d, v.l);
            end else begin
                gap++;
                if (gap == TO) begin v = judge(fbuf); complete(3'd4, v.d, v.l); end
            end
        end else if (cv && c == START_CH) begin
            in_frame = 1; fbuf.delete(); gap = 0;
        end
        exp_busy = in_frame || reporting;
        exp_valid = reporting;
    endtask

    task automatic tick(input logic cv, input logic [7:0] c, input logic r);
        @(negedge clk);
        char_valid = cv; char_in = c; rst = r;
        res_ready = ($urandom_range(0, 99) < rdy_pct);
        model_step(cv, c, res_ready, r);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_str(input string s, input int gmax);
        for (int i = 0; i < s.len(); i++) begin
            tick(1'b1, s[i], 1'b0);
            if (gmax > 0) idle($urandom_range(0, gmax));
        end
    endtask

    function automatic string rand_frame();
        string s;
        string seps;
        int nd, nl;
        seps = "+-*/=";
        s = "#";
        nd = $urandom_range(0, 5);
        for (int i = 0; i < nd; i++) s = {s, string'(8'h30 + 8'($urandom_range(0, 9)))};
        if ($urandom_range(0, 9) == 0) s = {s, "?"};
        else s = {s, string'(seps[$urandom_range(0, 4)])};
        nl = $urandom_range(0, 4);
        for (int i = 0; i < nl; i++) s = {s, string'(8'h41 + 8'($urandom_range(0, 25)))};
        if ($urandom_range(0, 9) == 0) s = {s, "7"};
        s = {s, "#"};
        return s;
    endfunction

    // Monitor: pop an expectation when a new result appears; compare all outputs each cycle.
    initial begin
        res_t cur;
        logic pv;
        cur = '0; pv = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cur = '0;
            end else if (res_valid === 1'b1 && pv !== 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else cur = exp_q.pop_front();
            end
            chk("res_valid", {31'd0, res_valid}, {31'd0, exp_valid});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("ok_count", 32'(ok_count), 32'(exp_ok));
            chk("bad_count", 32'(bad_count), 32'(exp_bad));
            chk("res_ok", {31'd0, res_ok}, {31'd0, cur.ok});
            chk("res_code", 32'(res_code), 32'(cur.code));
            chk("res_digits", 32'(res_digits), 32'(cur.d));
            chk("res_letters", 32'(res_letters), 32'(cur.l));
            pv = res_valid;
        end
    end

    // Stimulus: directed cases first, then randomised frames, gaps and backpressure.
    initial begin
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        send_str("#12+AB#", 0); idle(2);
        send_str("#1+A#", 0); idle(TO + 3);
        send_str("#12345", 0); idle(2);
        send_str("#12?", 0); idle(2);
        send_str("#12+ABCD", 0); idle(2);
        send_str("#12+#", 0); idle(2);
        send_str("#1", 0); idle(TO); idle(3);
        send_str("#1", 0); idle(TO - 1); send_str("2+A#", 0); idle(2);
        send_str("#12+", 0); idle(TO - 1); send_str("Q#", 0); idle(2);
        rdy_pct = 0;
        send_str("#12+AB#", 0); send_str("#99+Z#", 1); idle(10);
        rdy_pct = 100; idle(3);
        send_str("#12+A", 0); tick(1'b0, 8'h00, 1'b1); idle(2);
        for (int i = 0; i < 17; i++) begin send_str("#1234+XYZ#", 0); idle(1); end
        tick(1'b0, 8'h00, 1'b1); idle(2);
        for (int i = 0; i < 300; i++) begin
            rdy_pct = $urandom_range(20, 100);
            if ($urandom_range(0, 19) == 0) send_str("!5", 0);
            send_str(rand_frame(), ($urandom_range(0, 3) == 0) ? 2 : 0);
            if ($urandom_range(0, 24) == 0) idle(TO - 1 + $urandom_range(0, 1));
            else idle($urandom_range(0, 3));
        end
        rdy_pct = 100;
        idle(TO + 5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
